// File: rtl/pixel_row_packer_pkg.sv
// Shared defaults and helpers for the pixel row packer (row length, frame height, pixel width).
// Imported by the interface, the counter and the top.
package pixel_row_packer_pkg;

  localparam int unsigned ROW_DEFAULT   = 512;
  localparam int unsigned COL_DEFAULT   = 512;
  localparam int unsigned WIDTH_DEFAULT = 8;

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_row_packer_if.sv
// Pixel-in / row-out handshake bundle for pixel_row_packer.
// master: the packer itself; slave: the pixel source and row consumer.
interface pixel_row_packer_if import pixel_row_packer_pkg::*; #(
  parameter int unsigned ROW   = ROW_DEFAULT,
  parameter int unsigned COL   = COL_DEFAULT,
  parameter int unsigned width = WIDTH_DEFAULT
) ();

  localparam int unsigned ROW_BITS = ROW * width;
  localparam int unsigned RW       = clog2_min1(COL);

  logic [width-1:0]    pix_in;
  logic                pix_valid;
  logic                pix_sof;
  logic                pix_ready;
  logic [0:ROW_BITS-1] row_out;
  logic                row_valid;
  logic                row_ready;
  logic [RW-1:0]       row_idx;
  logic                row_last;
  logic                frame_done;

  modport master (
    input  pix_in, pix_valid, pix_sof, row_ready,
    output pix_ready, row_out, row_valid, row_idx, row_last, frame_done
  );

  modport slave (
    output pix_in, pix_valid, pix_sof, row_ready,
    input  pix_ready, row_out, row_valid, row_idx, row_last, frame_done
  );

endinterface

// File: rtl/pixel_row_packer_row_pack_counter.sv
// Column/row position tracking for pixel_row_packer: wrap, start-of-frame handling, completion.
// Build option SOF_RESYNC_EN: a mid-row sof drops the partial row and restarts at row 0.
module row_pack_counter import pixel_row_packer_pkg::*; #(
  parameter int unsigned ROW = ROW_DEFAULT,
  parameter int unsigned COL = COL_DEFAULT,
  localparam int unsigned CW = clog2_min1(ROW),
  localparam int unsigned RW = clog2_min1(COL)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          accept_i,
  input  logic          sof_i,
  input  logic          transfer_i,
  output logic [CW-1:0] wr_col_o,
  output logic [RW-1:0] row_cnt_o,
  output logic          complete_o
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          sof_hit, resync, at_last;

  assign sof_hit = accept_i & sof_i;
  assign at_last = (col_q == CW'(ROW - 1));

`ifdef SOF_RESYNC_EN
  assign resync = sof_hit & (col_q != '0);
`else
  assign resync = 1'b0;
`endif

  // A resynced sof pixel becomes pixel 0, so it can never complete a row.
  assign complete_o = accept_i & at_last & ~resync;
  assign wr_col_o   = resync ? '0 : col_q;
  assign row_cnt_o  = row_q;

  always_comb begin
    col_d = col_q;
    if (accept_i) begin
      if (resync) begin
        col_d = CW'(1);
      end else if (at_last) begin
        col_d = '0;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    row_d = row_q;
    if (sof_hit && ((col_q == '0) || resync)) begin
      row_d = '0;
    end else if (transfer_i) begin
      row_d = (row_q == RW'(COL - 1)) ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/pixel_row_packer.sv
// Packs a one-pixel-per-cycle raster stream into full rows, double-buffered (fill + out slot).
// Mid-row sof behaviour depends on SOF_RESYNC_EN (see row_pack_counter).
module pixel_row_packer import pixel_row_packer_pkg::*; #(
  parameter int unsigned ROW   = ROW_DEFAULT,
  parameter int unsigned COL   = COL_DEFAULT,
  parameter int unsigned width = WIDTH_DEFAULT
) (
  input  logic                CLK,
  input  logic                RST,
  pixel_row_packer_if.master  bus
);

  localparam int unsigned ROW_BITS = ROW * width;
  localparam int unsigned CW       = clog2_min1(ROW);
  localparam int unsigned RW       = clog2_min1(COL);

  logic [width-1:0]    fill_buf [ROW];
  logic [CW-1:0]       wr_col;
  logic [RW-1:0]       row_cnt;
  logic                complete, accept, slot_free, transfer, pix_ready;
  logic                fill_full_q, fill_full_d;
  logic                row_valid_q, row_valid_d;
  logic                row_last_q, frame_done_q;
  logic [RW-1:0]       row_idx_q;
  logic [0:ROW_BITS-1] row_out_q, row_next;

  assign pix_ready = RST & ~fill_full_q;
  assign accept    = bus.pix_valid & pix_ready;
  assign slot_free = ~row_valid_q | bus.row_ready;
  // Either a freshly completed row or a parked full row moves out once the slot frees.
  assign transfer  = (complete | fill_full_q) & slot_free;

  row_pack_counter #(
    .ROW (ROW),
    .COL (COL)
  ) u_counter (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .accept_i   (accept),
    .sof_i      (bus.pix_sof),
    .transfer_i (transfer),
    .wr_col_o   (wr_col),
    .row_cnt_o  (row_cnt),
    .complete_o (complete)
  );

  always_ff @(posedge CLK) begin
    if (accept) begin
      fill_buf[wr_col] <= bus.pix_in;
    end
  end

  // The final pixel bypasses fill_buf so the row can leave on its completion edge.
  always_comb begin
    row_next = '0;
    for (int k = 0; k < ROW; k++) begin
      row_next[k*width +: width] = fill_buf[k];
    end
    if (complete) begin
      row_next[(ROW-1)*width +: width] = bus.pix_in;
    end
  end

  always_comb begin
    fill_full_d = fill_full_q;
    if (complete && !slot_free) begin
      fill_full_d = 1'b1;
    end else if (fill_full_q && slot_free) begin
      fill_full_d = 1'b0;
    end
    row_valid_d = row_valid_q;
    if (transfer) begin
      row_valid_d = 1'b1;
    end else if (bus.row_ready) begin
      row_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fill_full_q  <= 1'b0;
      row_valid_q  <= 1'b0;
      row_out_q    <= '0;
      row_idx_q    <= '0;
      row_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      fill_full_q  <= fill_full_d;
      row_valid_q  <= row_valid_d;
      frame_done_q <= row_valid_q & bus.row_ready & row_last_q;
      if (transfer) begin
        row_out_q  <= row_next;
        row_idx_q  <= row_cnt;
        row_last_q <= (row_cnt == RW'(COL - 1));
      end
    end
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.row_out    = row_out_q;
  assign bus.row_valid  = row_valid_q;
  assign bus.row_idx    = row_idx_q;
  assign bus.row_last   = row_last_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_row_packer.sv
// Self-checking bench for pixel_row_packer (ROW=8, COL=3): scoreboard of expected rows
// produced by a pixel-level model, checked by a monitor on every row handshake.
module tb_pixel_row_packer;

  localparam int unsigned ROW = 8;
  localparam int unsigned COL = 3;
  localparam int unsigned W   = 8;
  localparam int unsigned RB  = ROW * W;
  localparam int unsigned RW  = $clog2(COL);
`ifdef SOF_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  typedef struct {
    logic [0:RB-1] data;
    logic [RW-1:0] idx;
    logic          last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t sb_q[$];

  logic [W-1:0] m_buf [ROW];
  int           m_col;
  int           m_row;

  pixel_row_packer_if #(.ROW(ROW), .COL(COL), .width(W)) bus ();

  pixel_row_packer #(
    .ROW   (ROW),
    .COL   (COL),
    .width (W)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one accepted pixel at a time, pushes a finished row to the scoreboard.
  task automatic model_push(input logic [W-1:0] v, input bit sof);
    exp_t e;
    if (sof && (m_col == 0 || RESYNC)) begin
      m_col = 0;
      m_row = 0;
    end
    m_buf[m_col] = v;
    if (m_col == ROW - 1) begin
      for (int k = 0; k < ROW; k++) e.data[k*W +: W] = m_buf[k];
      e.idx  = RW'(m_row);
      e.last = (m_row == COL - 1);
      sb_q.push_back(e);
      m_row = (m_row == COL - 1) ? 0 : m_row + 1;
      m_col = 0;
    end else begin
      m_col++;
    end
  endtask

  task automatic send_pix(input logic [W-1:0] v, input bit sof);
    int n;
    n = 0;
    bus.pix_in    = v;
    bus.pix_sof   = sof;
    bus.pix_valid = 1'b1;
    @(negedge clk);
    while (bus.pix_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.pix_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL pix_accept_timeout: pix_ready=%b, required 1 within 200 cycles",
               bus.pix_ready);
    end else begin
      model_push(v, sof);
    end
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d rows still expected, required 0", name, sb_q.size());
    end
  endtask

  task automatic monitor();
    logic [0:RB-1] prev_out;
    bit            prev_hold;
    bit            fd_exp;
    exp_t          e;
    prev_hold = 1'b0;
    fd_exp    = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
        fd_exp    = 1'b0;
      end else begin
        checks++;
        if (bus.frame_done !== fd_exp) begin
          errors++;
          $display("FAIL frame_done: got %b, required %b", bus.frame_done, fd_exp);
        end
        if (prev_hold) begin
          checks++;
          if (bus.row_out !== prev_out) begin
            errors++;
            $display("FAIL row_hold_stable: row_out=%h, required %h", bus.row_out, prev_out);
          end
        end
        fd_exp = 1'b0;
        if (bus.row_valid === 1'b1 && bus.row_ready === 1'b1) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_row: row_out=%h idx=%0d, required no row",
                     bus.row_out, bus.row_idx);
          end else begin
            e = sb_q.pop_front();
            if (bus.row_out !== e.data || bus.row_idx !== e.idx || bus.row_last !== e.last) begin
              errors++;
              $display("FAIL row_data: got %h idx=%0d last=%b, required %h idx=%0d last=%b",
                       bus.row_out, bus.row_idx, bus.row_last, e.data, e.idx, e.last);
            end
          end
          fd_exp = bus.row_last;
        end
        prev_hold = (bus.row_valid === 1'b1) && (bus.row_ready !== 1'b1);
        prev_out  = bus.row_out;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.row_valid !== 1'b0 || bus.row_out !== '0 || bus.row_idx !== '0 ||
        bus.row_last !== 1'b0 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b out=%h idx=%0d last=%b fd=%b, required all 0",
               bus.row_valid, bus.row_out, bus.row_idx, bus.row_last, bus.frame_done);
    end
    checks++;
    if (bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_pix_ready: got %b, required 0", bus.pix_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_pix_ready: got %b, required 1", bus.pix_ready);
    end
  endtask

  task automatic test_stream();
    bus.row_ready = 1'b1;
    for (int k = 0; k < 2 * ROW; k++) begin
      send_pix(W'(k), k == 0);
      if (k == ROW - 2) begin
        checks++;
        if (bus.row_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_early_valid: row_valid=%b, required 0", bus.row_valid);
        end
      end
      if (k == ROW - 1) begin
        checks++;
        if (bus.row_valid !== 1'b1) begin
          errors++;
          $display("FAIL stream_latency: row_valid=%b, required 1", bus.row_valid);
        end
      end
    end
    wait_drain("stream");
  endtask

  task automatic test_backpressure();
    bus.row_ready = 1'b0;
    for (int k = 0; k < 2 * ROW; k++) send_pix(W'(3 * k + 1), 1'b0);
    checks++;
    if (bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_pix_ready_drop: got %b, required 0", bus.pix_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.row_valid !== 1'b1 || bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: valid=%b pix_ready=%b, required 1 and 0",
               bus.row_valid, bus.pix_ready);
    end
    bus.row_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.row_valid !== 1'b1 || bus.pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_bubble: valid=%b pix_ready=%b, required 1 and 1",
               bus.row_valid, bus.pix_ready);
    end
    wait_drain("backpressure");
  endtask

  task automatic test_frame();
    bus.row_ready = 1'b1;
    for (int r = 0; r < COL + 1; r++) begin
      for (int k = 0; k < ROW; k++) send_pix(W'(8'h80 + 16 * r + k), r == 0 && k == 0);
    end
    wait_drain("frame");
  endtask

  task automatic test_reset_mid_row();
    bus.row_ready = 1'b1;
    for (int k = 0; k < ROW + 3; k++) send_pix(W'(8'h20 + k), 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.row_valid !== 1'b0 || bus.row_out !== '0 || bus.row_idx !== '0 ||
        bus.row_last !== 1'b0 || bus.frame_done !== 1'b0 || bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: valid=%b out=%h idx=%0d pix_ready=%b, required all 0",
               bus.row_valid, bus.row_out, bus.row_idx, bus.pix_ready);
    end
    sb_q.delete();
    m_col = 0;
    m_row = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < ROW; k++) send_pix(W'(8'hA0 + k), 1'b0);
    wait_drain("midreset");
  endtask

  task automatic test_sof_mid();
    bus.row_ready = 1'b1;
    for (int k = 0; k < 5; k++) send_pix(W'(8'h40 + k), 1'b0);
    send_pix(8'h50, 1'b1);
    for (int k = 1; k < ROW; k++) send_pix(W'(8'h50 + k), 1'b0);
    while (m_col != 0) send_pix(W'(8'h60 + m_col), 1'b0);
    wait_drain("sof_mid");
  endtask

  task automatic test_simultaneous();
    bus.row_ready = 1'b0;
    for (int k = 0; k < ROW; k++) send_pix(W'(8'hC0 + k), 1'b0);
    for (int k = 0; k < ROW - 1; k++) send_pix(W'(8'hD0 + k), 1'b0);
    bus.row_ready = 1'b1;
    send_pix(W'(8'hD0 + ROW - 1), 1'b0);
    checks++;
    if (!(bus.row_valid === 1'b1 && sb_q.size() == 1 && bus.row_out === sb_q[0].data)) begin
      errors++;
      $display("FAIL simul_replace: valid=%b out=%h pending=%0d, required valid=1 new row %h",
               bus.row_valid, bus.row_out, sb_q.size(), sb_q[0].data);
    end
    wait_drain("simultaneous");
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    m_col         = 0;
    m_row         = 0;
    rst_n         = 1'b0;
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.row_ready = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_stream();
    test_backpressure();
    test_frame();
    test_reset_mid_row();
    test_sof_mid();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
